// File: rtl/pisca_pkg.sv
// Shared types and defaults for the multi-channel LED driver.
package pisca_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } modo_t;

  localparam int CNT_W_DEF     = 8;
  localparam int PRESC_DIV_DEF = 1024;

  // Width needed to index n items, never below one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pisca_canal.sv
// One LED channel: mode/period/duty registers, tick counter and registered LED.
module pisca_canal
  import pisca_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             wr,
  input  logic [1:0]       wmode,
  input  logic [CNT_W-1:0] wperiod,
  input  logic [CNT_W-1:0] wduty,
  output logic             led
);

  modo_t            mode, mode_n;
  logic [CNT_W-1:0] p, p_n, d, d_n, cnt, cnt_n, cnt_inc;
  logic             led_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode <= MODE_OFF;
      p    <= '0;
      d    <= '0;
      cnt  <= '0;
      led  <= 1'b0;
    end else begin
      mode <= mode_n;
      p    <= p_n;
      d    <= d_n;
      cnt  <= cnt_n;
      led  <= led_n;
    end
  end

  // cnt is compared against P before incrementing, so it never wraps.
  assign cnt_inc = (cnt == p) ? '0 : cnt + CNT_W'(1);

  always_comb begin
    mode_n = mode;
    p_n    = p;
    d_n    = d;
    cnt_n  = cnt;
    led_n  = led;
    if (wr) begin
      // A write on a tick cycle discards that tick for this channel.
      mode_n = modo_t'(wmode);
      p_n    = wperiod;
      d_n    = wduty;
      cnt_n  = '0;
      case (modo_t'(wmode))
        MODE_ON:  led_n = 1'b1;
        MODE_PWM: led_n = (wduty != '0);
        default:  led_n = 1'b0;
      endcase
    end else if (tick) begin
      case (mode)
        MODE_OFF: begin
          led_n = 1'b0;
          cnt_n = '0;
        end
        MODE_ON: begin
          led_n = 1'b1;
          cnt_n = '0;
        end
        MODE_BLINK: begin
          cnt_n = cnt_inc;
          if (cnt == p) led_n = ~led;
        end
        default: begin
          cnt_n = cnt_inc;
          led_n = (cnt_inc < d);
        end
      endcase
    end
  end

endmodule

// File: rtl/pisca_leds_multi.sv
// Multi-channel LED driver: shared prescaler tick, write decode, N_CH channels.
module pisca_leds_multi
  import pisca_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int PRESC_DIV = PRESC_DIV_DEF,
  parameter int AW        = clog2_min1(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [1:0]       wmode,
  input  logic [CNT_W-1:0] wperiod,
  input  logic [CNT_W-1:0] wduty,
  output logic             tick,
  output logic [N_CH-1:0]  leds
);

  localparam int            PW        = clog2_min1(PRESC_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC_DIV - 1);

  logic [PW-1:0]   presc;
  logic [N_CH-1:0] wr;

  // With PRESC_DIV=1 presc stays at 0 and tick is permanently high.
  assign tick = (presc == PRESC_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + PW'(1);
  end

  // Addresses at or above N_CH match no channel and are dropped.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign wr[gi] = we && (addr == AW'(gi));

    pisca_canal #(
      .CNT_W (CNT_W)
    ) u_canal (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .wr      (wr[gi]),
      .wmode   (wmode),
      .wperiod (wperiod),
      .wduty   (wduty),
      .led     (leds[gi])
    );
  end

endmodule

// File: tb/tb_pisca_leds_multi.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, monitor checks them.
module tb_pisca_leds_multi;
  import pisca_pkg::*;

  typedef struct {
    int         cyc;
    int         sig;
    logic [3:0] exp;
    string      name;
  } chk_t;

  localparam int S_LA = 0, S_TA = 1, S_LB = 2, S_TB = 3, S_LC = 4, S_TC = 5;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  chk_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // dut_a: default parameters
  logic       rst_a = 1'b1, we_a = 1'b0, tick_a;
  logic [1:0] addr_a = '0, wmode_a = '0;
  logic [7:0] wper_a = '0, wduty_a = '0;
  logic [3:0] leds_a;

  // dut_b: 3 channels, 2-bit address, tick every 4 cycles
  logic       rst_b = 1'b1, we_b = 1'b0, tick_b;
  logic [1:0] addr_b = '0, wmode_b = '0;
  logic [7:0] wper_b = '0, wduty_b = '0;
  logic [2:0] leds_b;

  // dut_c: tick every cycle
  logic       rst_c = 1'b1, we_c = 1'b0, tick_c;
  logic [1:0] addr_c = '0, wmode_c = '0;
  logic [7:0] wper_c = '0, wduty_c = '0;
  logic [3:0] leds_c;

  pisca_leds_multi dut_a (
    .clk(clk), .rst(rst_a), .we(we_a), .addr(addr_a), .wmode(wmode_a),
    .wperiod(wper_a), .wduty(wduty_a), .tick(tick_a), .leds(leds_a)
  );

  pisca_leds_multi #(.N_CH(3), .CNT_W(8), .PRESC_DIV(4)) dut_b (
    .clk(clk), .rst(rst_b), .we(we_b), .addr(addr_b), .wmode(wmode_b),
    .wperiod(wper_b), .wduty(wduty_b), .tick(tick_b), .leds(leds_b)
  );

  pisca_leds_multi #(.N_CH(4), .CNT_W(8), .PRESC_DIV(1)) dut_c (
    .clk(clk), .rst(rst_c), .we(we_c), .addr(addr_c), .wmode(wmode_c),
    .wperiod(wper_c), .wduty(wduty_c), .tick(tick_c), .leds(leds_c)
  );

  task automatic expect_at(input int c, input int s, input logic [3:0] e, input string n);
    chk_t t;
    t.cyc  = c;
    t.sig  = s;
    t.exp  = e;
    t.name = n;
    sb.push_back(t);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic write_b(input logic [1:0] a, input logic [1:0] m, input logic [7:0] p, input logic [7:0] d);
    we_b = 1'b1; addr_b = a; wmode_b = m; wper_b = p; wduty_b = d;
    @(negedge clk);
    we_b = 1'b0;
  endtask

  task automatic write_c(input logic [1:0] a, input logic [1:0] m, input logic [7:0] p, input logic [7:0] d);
    we_c = 1'b1; addr_c = a; wmode_c = m; wper_c = p; wduty_c = d;
    @(negedge clk);
    we_c = 1'b0;
  endtask

  // Monitor: outputs are sampled on the falling edge, away from state updates.
  always @(negedge clk) begin
    logic [3:0] act;
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].cyc <= cyc) begin
        case (sb[k].sig)
          S_LA:    act = leds_a;
          S_TA:    act = {3'b000, tick_a};
          S_LB:    act = {1'b0, leds_b};
          S_TB:    act = {3'b000, tick_b};
          S_LC:    act = leds_c;
          default: act = {3'b000, tick_c};
        endcase
        checks++;
        if (sb[k].cyc < cyc) begin
          errors++;
          $display("FAIL %s: check missed at cycle %0d (now %0d)", sb[k].name, sb[k].cyc, cyc);
        end else if (act !== sb[k].exp) begin
          errors++;
          $display("FAIL %s: cycle %0d got %b expected %b", sb[k].name, cyc, act, sb[k].exp);
        end
        sb.delete(k);
      end
    end
  end

  initial begin
    int a0, b0, r0, c0, w, x, y;

    // Reset state of every instance while rst is held.
    for (int c = 1; c <= 2; c++) begin
      expect_at(c, S_LA, 4'h0, "rst_leds_a");
      expect_at(c, S_TA, 4'h0, "rst_tick_a");
      expect_at(c, S_LB, 4'h0, "rst_leds_b");
      expect_at(c, S_TB, 4'h0, "rst_tick_b");
      expect_at(c, S_LC, 4'h0, "rst_leds_c");
      expect_at(c, S_TC, 4'h1, "rst_tick_c_div1");
    end
    wait_until(3);

    // No writes, default parameters: leds idle, tick at 1023 and every 1024.
    a0 = cyc;
    rst_a = 1'b0;
    for (int k = 250; k <= 5000; k += 250) expect_at(a0 + k, S_LA, 4'h0, "idle_leds_a");
    expect_at(a0 + 1,    S_TA, 4'h0, "tick_a_early");
    expect_at(a0 + 1022, S_TA, 4'h0, "tick_a_1022");
    expect_at(a0 + 1023, S_TA, 4'h1, "tick_a_1023");
    expect_at(a0 + 1024, S_TA, 4'h0, "tick_a_1024");
    expect_at(a0 + 2047, S_TA, 4'h1, "tick_a_2047");
    expect_at(a0 + 3071, S_TA, 4'h1, "tick_a_3071");
    expect_at(a0 + 4095, S_TA, 4'h1, "tick_a_4095");
    expect_at(a0 + 4096, S_TA, 4'h0, "tick_a_4096");
    wait_until(a0 + 5001);

    // dut_b: BLINK/ON, write-on-tick, out-of-range address, async reset.
    b0 = cyc;
    rst_b = 1'b0;
    expect_at(b0 + 2,  S_TB, 4'h0, "tick_b_2");
    expect_at(b0 + 3,  S_TB, 4'h1, "tick_b_3");
    expect_at(b0 + 4,  S_TB, 4'h0, "tick_b_4");
    expect_at(b0 + 5,  S_LB, 4'b000, "blink_after_wr");
    expect_at(b0 + 6,  S_LB, 4'b010, "on_next_cycle");
    expect_at(b0 + 15, S_LB, 4'b010, "blink_hold");
    expect_at(b0 + 16, S_LB, 4'b011, "blink_toggle1");
    expect_at(b0 + 27, S_LB, 4'b011, "blink_hold2");
    expect_at(b0 + 28, S_LB, 4'b010, "blink_toggle2");
    expect_at(b0 + 40, S_LB, 4'b011, "blink_toggle3");
    expect_at(b0 + 41, S_LB, 4'b011, "pre_rewrite");
    expect_at(b0 + 42, S_LB, 4'b001, "ch1_blink_wr");
    expect_at(b0 + 44, S_LB, 4'b011, "ch1_p0_tog");
    expect_at(b0 + 48, S_LB, 4'b001, "ch1_p0_tog2");
    expect_at(b0 + 51, S_TB, 4'h1, "tick_at_wr");
    expect_at(b0 + 51, S_LB, 4'b001, "pre_wr_on_tick");
    expect_at(b0 + 52, S_LB, 4'b011, "wr_wins_tick");
    expect_at(b0 + 56, S_LB, 4'b001, "pwm_cnt_from0");
    expect_at(b0 + 60, S_LB, 4'b010, "pwm_low");
    expect_at(b0 + 64, S_LB, 4'b000, "pwm_low2");
    expect_at(b0 + 68, S_LB, 4'b011, "pwm_frame");
    expect_at(b0 + 70, S_LB, 4'b011, "bad_addr_ignored");
    expect_at(b0 + 71, S_LB, 4'b011, "bad_addr_ignored2");
    expect_at(b0 + 72, S_LB, 4'b001, "after_bad_addr");
    expect_at(b0 + 73, S_LB, 4'b001, "pre_rst");
    expect_at(b0 + 74, S_LB, 4'b000, "async_rst_leds");
    expect_at(b0 + 74, S_TB, 4'h0, "async_rst_tick");
    expect_at(b0 + 75, S_LB, 4'b000, "rst_held");
    wait_until(b0 + 4);
    write_b(2'd0, MODE_BLINK, 8'd2, 8'd0);
    write_b(2'd1, MODE_ON, 8'd0, 8'd0);
    wait_until(b0 + 41);
    write_b(2'd1, MODE_BLINK, 8'd0, 8'd0);
    wait_until(b0 + 51);
    write_b(2'd0, MODE_PWM, 8'd3, 8'd2);
    wait_until(b0 + 69);
    write_b(2'd3, MODE_OFF, 8'd0, 8'd0);
    wait_until(b0 + 73);
    @(posedge clk);
    #2 rst_b = 1'b1;
    @(negedge clk);
    @(negedge clk);
    r0 = cyc;
    rst_b = 1'b0;
    expect_at(r0 + 2, S_TB, 4'h0, "tick_b_post_rst2");
    expect_at(r0 + 3, S_TB, 4'h1, "tick_b_post_rst3");
    expect_at(r0 + 3, S_LB, 4'b000, "leds_b_post_rst");
    wait_until(r0 + 5);

    // dut_c: PWM P=9 with D=3, D=0 and D=12 at one tick per cycle.
    c0 = cyc;
    rst_c = 1'b0;
    w = c0 + 2;
    x = w + 20;
    y = x + 20;
    expect_at(c0 + 1, S_TC, 4'h1, "tick_c_const");
    expect_at(w + 1,  S_LC, 4'b0100, "pwm_d3_c1");
    expect_at(w + 3,  S_LC, 4'b0100, "pwm_d3_c3");
    expect_at(w + 4,  S_LC, 4'b0000, "pwm_d3_c4");
    expect_at(w + 10, S_LC, 4'b0000, "pwm_d3_c10");
    expect_at(w + 11, S_LC, 4'b0100, "pwm_d3_c11");
    expect_at(w + 13, S_LC, 4'b0100, "pwm_d3_c13");
    expect_at(w + 14, S_LC, 4'b0000, "pwm_d3_c14");
    expect_at(x + 1,  S_LC, 4'b0000, "pwm_d0_a");
    expect_at(x + 5,  S_LC, 4'b0000, "pwm_d0_b");
    expect_at(x + 11, S_LC, 4'b0000, "pwm_d0_c");
    expect_at(y + 1,  S_LC, 4'b0100, "pwm_d12_a");
    expect_at(y + 6,  S_LC, 4'b0100, "pwm_d12_b");
    expect_at(y + 10, S_LC, 4'b0100, "pwm_d12_c");
    expect_at(y + 11, S_LC, 4'b0100, "pwm_d12_d");
    wait_until(w);
    write_c(2'd2, MODE_PWM, 8'd9, 8'd3);
    wait_until(x);
    write_c(2'd2, MODE_PWM, 8'd9, 8'd0);
    wait_until(y);
    write_c(2'd2, MODE_PWM, 8'd9, 8'd12);
    wait_until(y + 15);

    foreach (sb[k]) begin
      checks++;
      errors++;
      $display("FAIL %s: never sampled (due cycle %0d)", sb[k].name, sb[k].cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
